// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT pointwise-multiply front end.
//   NTT_N     : default polynomial length (coefficient pairs per frame)
//   NTT_WIDTH : default coefficient bit width
//   NTT_Q     : default modulus (2*Q must fit in WIDTH bits)
//   loader_state_e : coefficient loader FSM states
// ---------------------------------------------------------------------------
package ntt_pkg;

    localparam int NTT_N     = 256;
    localparam int NTT_WIDTH = 32;
    localparam int NTT_Q     = 8380417;

    // FILL collects beats, FULL presents the completed polynomials.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/ntt_coeff_reduce.sv
// ---------------------------------------------------------------------------
// ntt_coeff_reduce
// Combinational single conditional subtract that folds an input in [0, 2Q)
// into [0, Q), and flags when the fold was needed. Only instantiated by
// ntt_coeff_loader when NTT_LOADER_RANGE_CHECK_EN is defined.
// Ports:
//   x            in  WIDTH  raw coefficient
//   y            out WIDTH  x - Q if x >= Q, else x
//   out_of_range out 1      x >= Q
// ---------------------------------------------------------------------------
module ntt_coeff_reduce #(
    parameter int WIDTH = 32,
    parameter int Q     = 8380417
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             out_of_range
);

    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    // Inputs at or above 2Q are outside the contract, so one subtract is enough.
    always_comb begin
        out_of_range = (x >= QW);
        y            = out_of_range ? (x - QW) : x;
    end

endmodule

// File: rtl/ntt_coeff_loader.sv
// ---------------------------------------------------------------------------
// ntt_coeff_loader
// Streaming front end for the parallel pointwise multiplier. Collects N
// coefficient pairs (A[i], B[i]), one per accepted beat, into parallel
// register arrays and presents them as whole polynomials over valid/ready.
// Optional macro NTT_LOADER_RANGE_CHECK_EN: fold coefficients >= Q by one
// subtract and raise a sticky range_err (cleared by rst_n or flush).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous drop of the current frame
//   in_valid/in_ready   input beat handshake; in_a, in_b, in_last payload
//   poly_a, poly_b      collected polynomials [N-1:0]
//   poly_valid/ready    polynomial handshake to the multiplier
//   fill_count          beats accepted in this frame (N while FULL)
//   len_err             one-cycle pulse on in_last misalignment
//   range_err           sticky out-of-range flag (0 without the macro)
// ---------------------------------------------------------------------------
module ntt_coeff_loader
    import ntt_pkg::*;
#(
    parameter int N     = NTT_N,
    parameter int WIDTH = NTT_WIDTH,
    parameter int Q     = NTT_Q
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_last,
    output logic [WIDTH-1:0]       poly_a [N-1:0],
    output logic [WIDTH-1:0]       poly_b [N-1:0],
    output logic                   poly_valid,
    input  logic                   poly_ready,
    output logic [$clog2(N):0]     fill_count,
    output logic                   len_err,
    output logic                   range_err
);

    localparam int IDX_W = $clog2(N);

    // The conditional subtract relies on 2Q being representable in WIDTH bits.
    if ((64'(Q) * 64'd2) >= (64'd1 << WIDTH)) begin : g_q_check
        $error("ntt_coeff_loader: 2*Q must be below 2**WIDTH");
    end

    loader_state_e    state, next_state;
    logic [IDX_W-1:0] count, next_count;
    logic             next_len_err;
    logic             wr_en;
    logic             at_last;
    logic [WIDTH-1:0] store_a, store_b;

    assign at_last    = (count == IDX_W'(N - 1));
    assign in_ready   = (state == FILL);
    assign poly_valid = (state == FULL);
    assign fill_count = (state == FULL) ? (IDX_W + 1)'(N) : {1'b0, count};

`ifdef NTT_LOADER_RANGE_CHECK_EN
    logic a_oor, b_oor;

    ntt_coeff_reduce #(.WIDTH(WIDTH), .Q(Q)) u_reduce_a (
        .x            (in_a),
        .y            (store_a),
        .out_of_range (a_oor)
    );

    ntt_coeff_reduce #(.WIDTH(WIDTH), .Q(Q)) u_reduce_b (
        .x            (in_b),
        .y            (store_b),
        .out_of_range (b_oor)
    );

    // Sticky range flag: only stored coefficients count; flush clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            range_err <= 1'b0;
        else if (flush)
            range_err <= 1'b0;
        else if (wr_en && (a_oor || b_oor))
            range_err <= 1'b1;
    end
`else
    assign store_a   = in_a;
    assign store_b   = in_b;
    assign range_err = 1'b0;
`endif

    // State, beat counter and length-error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            count   <= '0;
            len_err <= 1'b0;
        end else begin
            state   <= next_state;
            count   <= next_count;
            len_err <= next_len_err;
        end
    end

    // Next-state logic. flush outranks everything; an early in_last drops
    // the frame without writing, while a missing in_last on the final beat
    // still completes the frame but reports the misalignment.
    always_comb begin
        next_state   = state;
        next_count   = count;
        next_len_err = 1'b0;
        wr_en        = 1'b0;
        if (flush) begin
            next_state = FILL;
            next_count = '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        if (in_last && !at_last) begin
                            next_count   = '0;
                            next_len_err = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            if (at_last) begin
                                next_state   = FULL;
                                next_count   = '0;
                                next_len_err = !in_last;
                            end else begin
                                next_count = count + IDX_W'(1);
                            end
                        end
                    end
                end
                FULL: begin
                    if (poly_ready)
                        next_state = FILL;
                end
                default: next_state = FILL;
            endcase
        end
    end

    // Coefficient arrays. Frames overwrite every entry, so they are only
    // cleared by reset, never between frames or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                poly_a[i] <= '0;
                poly_b[i] <= '0;
            end
        end else if (wr_en) begin
            poly_a[count] <= store_a;
            poly_b[count] <= store_b;
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_ntt_coeff_loader
// Self-checking bench for ntt_coeff_loader. Stimulus tasks update a
// behavioural model of the loader (a frame position, a full flag and the
// expected array contents) and push each completed frame into a queue; an
// independent monitor pops and compares whenever poly_valid rises.
// ---------------------------------------------------------------------------
module tb_ntt_coeff_loader;
    import ntt_pkg::*;

    localparam int N     = NTT_N;
    localparam int WIDTH = NTT_WIDTH;
    localparam int Q     = NTT_Q;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic [WIDTH-1:0] poly_a [N-1:0];
    logic [WIDTH-1:0] poly_b [N-1:0];
    logic             poly_valid;
    logic             poly_ready;
    logic [$clog2(N):0] fill_count;
    logic             len_err;
    logic             range_err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state.
    int               modelPos;
    bit               modelFull;
    bit               modelRange;
    logic [WIDTH-1:0] modelA [N];
    logic [WIDTH-1:0] modelB [N];
    logic [WIDTH-1:0] expA [$];
    logic [WIDTH-1:0] expB [$];

    ntt_coeff_loader #(.N(N), .WIDTH(WIDTH), .Q(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .poly_a     (poly_a),
        .poly_b     (poly_b),
        .poly_valid (poly_valid),
        .poly_ready (poly_ready),
        .fill_count (fill_count),
        .len_err    (len_err),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison with counting and one-line failure report.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // What the loader should store for an accepted coefficient.
    function automatic logic [WIDTH-1:0] storedValue(input logic [WIDTH-1:0] x);
`ifdef NTT_LOADER_RANGE_CHECK_EN
        if (x >= WIDTH'(Q))
            return x - WIDTH'(Q);
`endif
        return x;
    endfunction

    function automatic bit outOfRange(input logic [WIDTH-1:0] x);
`ifdef NTT_LOADER_RANGE_CHECK_EN
        return x >= WIDTH'(Q);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] randCoeff();
        return WIDTH'($urandom_range(0, 2 * Q - 1));
    endfunction

    function automatic void modelReset();
        modelPos   = 0;
        modelFull  = 1'b0;
        modelRange = 1'b0;
        for (int i = 0; i < N; i++) begin
            modelA[i] = '0;
            modelB[i] = '0;
        end
    endfunction

    // One clock of stimulus: drive, clock, advance the model, then check
    // the cycle-level outputs against it. Called at posedge+1.
    task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit last, input bit fl);
        bit expLen;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
        expLen   = 1'b0;
        if (fl) begin
            modelPos   = 0;
            modelFull  = 1'b0;
            modelRange = 1'b0;
        end else if (modelFull) begin
            if (poly_ready)
                modelFull = 1'b0;
        end else if (v) begin
            if (last && modelPos != N - 1) begin
                modelPos = 0;
                expLen   = 1'b1;
            end else begin
                modelA[modelPos] = storedValue(a);
                modelB[modelPos] = storedValue(b);
                if (outOfRange(a) || outOfRange(b))
                    modelRange = 1'b1;
                if (modelPos == N - 1) begin
                    for (int i = 0; i < N; i++) begin
                        expA.push_back(modelA[i]);
                        expB.push_back(modelB[i]);
                    end
                    modelPos  = 0;
                    modelFull = 1'b1;
                    expLen    = !last;
                end else begin
                    modelPos++;
                end
            end
        end
        checkOutput("len_err", len_err, expLen);
        checkOutput("fill_count", fill_count, modelFull ? N : modelPos);
        checkOutput("in_ready", in_ready, !modelFull);
        checkOutput("poly_valid", poly_valid, modelFull);
        checkOutput("range_err", range_err, modelRange);
    endtask

    // Idle cycle with junk on the data lines (in_last toggles while invalid).
    task automatic idleCycle();
        applyStimulus(1'b0, randCoeff(), randCoeff(), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Beats 0..count-1 of a frame. mode 0: a=i, b=2i; mode 1: random;
    // mode 2: random with a[0]=7. dropLast suppresses in_last on beat N-1.
    task automatic sendBeats(input int count, input int mode, input int bubblePct, input bit dropLast);
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(0, 99) < bubblePct)
                idleCycle();
            if (mode == 0) begin
                a = WIDTH'(i);
                b = WIDTH'(2 * i);
            end else begin
                a = (mode == 2 && i == 0) ? WIDTH'(7) : randCoeff();
                b = randCoeff();
            end
            applyStimulus(1'b1, a, b, (i == N - 1) && !dropLast, 1'b0);
        end
    endtask

    // Hand the presented frame downstream with a one-cycle poly_ready pulse.
    task automatic releaseFrame();
        poly_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        poly_ready = 1'b0;
    endtask

    task automatic checkArraysZero(input string name);
        int nonZero;
        nonZero = 0;
        for (int i = 0; i < N; i++)
            if (poly_a[i] !== '0 || poly_b[i] !== '0)
                nonZero++;
        checkOutput(name, nonZero, 0);
    endtask

    // Asynchronous reset in the middle of whatever is happening.
    task automatic doReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        checkArraysZero("async_reset_arrays");
        checkOutput("async_reset_fill_count", fill_count, 0);
        checkOutput("async_reset_poly_valid", poly_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: each time a frame is presented, pop and compare N pairs.
    bit prevValid = 1'b0;
    always @(negedge clk) begin
        int bad, firstBad;
        logic [WIDTH-1:0] ea, eb, fa, fb;
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (poly_valid && !prevValid) begin
                testsRun++;
                if (expA.size() < N) begin
                    testsFailed++;
                    $display("[TB] FAIL frame_pop: poly_valid rose with %0d words queued, need %0d", expA.size(), N);
                end else begin
                    bad = 0;
                    firstBad = -1;
                    fa = '0;
                    fb = '0;
                    for (int i = 0; i < N; i++) begin
                        ea = expA.pop_front();
                        eb = expB.pop_front();
                        if (poly_a[i] !== ea || poly_b[i] !== eb) begin
                            if (bad == 0) begin
                                firstBad = i;
                                fa = ea;
                                fb = eb;
                            end
                            bad++;
                        end
                    end
                    if (bad != 0) begin
                        testsFailed++;
                        $display("[TB] FAIL frame_data: %0d entries differ, first [%0d] got a=%0d b=%0d, expected a=%0d b=%0d",
                                 bad, firstBad, poly_a[firstBad], poly_b[firstBad], fa, fb);
                    end
                end
            end
            prevValid = poly_valid;
        end
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_last    = 1'b0;
        poly_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_poly_valid", poly_valid, 0);
        checkOutput("reset_fill_count", fill_count, 0);
        checkOutput("reset_len_err", len_err, 0);
        checkOutput("reset_range_err", range_err, 0);
        checkArraysZero("reset_arrays");

        // Normal fill: ramp, no bubbles, held FULL by poly_ready=0.
        $display("[TB] normal fill");
        sendBeats(N, 0, 0, 1'b0);
        checkOutput("ramp_a_last", poly_a[N-1], N - 1);
        checkOutput("ramp_b_last", poly_b[N-1], 2 * (N - 1));

        // Backpressure: ten offered beats while FULL must be ignored.
        $display("[TB] backpressure");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, WIDTH'(7), WIDTH'(7), 1'b0, 1'b0);
        checkOutput("bp_a0_held", poly_a[0], 0);
        releaseFrame();
        sendBeats(N, 2, 20, 1'b0);
        checkOutput("overwrite_a0", poly_a[0], 7);
        releaseFrame();

        // Bubbles on a ramp frame.
        $display("[TB] bubbles");
        sendBeats(N, 0, 40, 1'b0);
        releaseFrame();

        // Early in_last at index 9, then a clean frame.
        $display("[TB] early in_last");
        sendBeats(9, 1, 10, 1'b0);
        applyStimulus(1'b1, randCoeff(), randCoeff(), 1'b1, 1'b0);
        sendBeats(N, 1, 10, 1'b0);
        releaseFrame();

        // Missing in_last on the final beat: frame completes, len_err pulses.
        $display("[TB] missing in_last");
        sendBeats(N, 1, 10, 1'b1);
        releaseFrame();

        // Asynchronous reset at beat 100.
        $display("[TB] reset mid-frame");
        sendBeats(100, 1, 10, 1'b0);
        doReset();
        checkOutput("post_reset_in_ready", in_ready, 1);
        sendBeats(N, 1, 10, 1'b0);
        releaseFrame();

        // Flush at beat 50 with a live beat presented that cycle.
        $display("[TB] flush mid-frame");
        sendBeats(50, 1, 10, 1'b0);
        applyStimulus(1'b1, randCoeff(), randCoeff(), 1'b0, 1'b1);
        sendBeats(N, 1, 10, 1'b0);

        // Flush while FULL drops poly_valid the next cycle.
        $display("[TB] flush while full");
        idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

        // Out-of-range coefficient at index 0; flag stays until flush.
        $display("[TB] range check");
        applyStimulus(1'b1, WIDTH'(Q + 5), WIDTH'(3), 1'b0, 1'b0);
        sendBeats(N - 1, 1, 10, 1'b0);
        checkOutput("range_a0", poly_a[0], storedValue(WIDTH'(Q + 5)));
        checkOutput("range_b0", poly_b[0], 3);
        releaseFrame();
        idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

        // Random frames with random downstream hold times.
        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            sendBeats(N, 1, 25, 1'b0);
            repeat ($urandom_range(0, 5)) idleCycle();
            releaseFrame();
        end

        idleCycle();
        checkOutput("frames_pending", expA.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
